// File: rtl/adder_pkg.sv
// Shared constants for the adder block: legal width ceiling and register reset value.
package adder_pkg;
    localparam int   ADDER_MAX_WIDTH = 64;
    localparam logic ADDER_RST_VAL   = 1'b0;
endpackage

// File: rtl/adder_if.sv
// Operand/result bundle for the adder. The overflow signal exists only when ADDER_OVERFLOW_EN is defined.
interface adder_if #(parameter int WIDTH = 4);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             out_valid;
`ifdef ADDER_OVERFLOW_EN
    logic             overflow;

    modport master (output in_valid, a, b, carry_in,
                    input  sum, carry_out, out_valid, overflow);
    modport slave  (input  in_valid, a, b, carry_in,
                    output sum, carry_out, out_valid, overflow);
`else
    modport master (output in_valid, a, b, carry_in,
                    input  sum, carry_out, out_valid);
    modport slave  (input  in_valid, a, b, carry_in,
                    output sum, carry_out, out_valid);
`endif
endinterface

// File: rtl/adder_full_adder.sv
// One-bit full-adder cell; the adder top ripples WIDTH of these.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic p;

    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);
endmodule

// File: rtl/adder.sv
// Registered WIDTH-bit ripple-carry adder, latency 1. Optional signed overflow output under ADDER_OVERFLOW_EN.
module adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    adder_if.slave bus
);
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    if (WIDTH < 1 || WIDTH > ADDER_MAX_WIDTH) begin : g_bad_width
        $error("adder: WIDTH out of range");
    end

    assign c[0] = bus.carry_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        full_adder u_fa (
            .a   (bus.a[i]),
            .b   (bus.b[i]),
            .cin (c[i]),
            .s   (s[i]),
            .cout(c[i+1])
        );
    end

    // Result registers only load on accepted operands; otherwise they hold the last result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.sum       <= {WIDTH{ADDER_RST_VAL}};
            bus.carry_out <= ADDER_RST_VAL;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.sum       <= s;
                bus.carry_out <= c[WIDTH];
            end
        end
    end

`ifdef ADDER_OVERFLOW_EN
    // Signed overflow: carries into and out of the sign bit disagree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.overflow <= ADDER_RST_VAL;
        end else if (bus.in_valid) begin
            bus.overflow <= c[WIDTH] ^ c[WIDTH-1];
        end
    end
`endif
endmodule

// File: tb/tb_adder.sv
// Bench for adder: WIDTH=1/4/32 instances, table vectors plus random sweep against a scoreboard.
module tb_adder;
    typedef struct packed {
        logic [63:0] s;
        logic        co;
        logic        ov;
    } exp_t;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] s;
        logic       co;
        logic       ov;
    } vec_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    exp_t q[3][$];
    exp_t last[3];

    adder_if #(.WIDTH(1))  if1 ();
    adder_if #(.WIDTH(4))  if4 ();
    adder_if #(.WIDTH(32)) if32 ();

    adder #(.WIDTH(1))  u_dut1  (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    adder #(.WIDTH(4))  u_dut4  (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
    adder #(.WIDTH(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(if32.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wid(input int k);
        return (k == 0) ? 1 : (k == 1) ? 4 : 32;
    endfunction

    function automatic exp_t model(input int k, input logic [63:0] a, input logic [63:0] b, input logic cin);
        exp_t        r;
        int          w;
        logic [63:0] mk;
        logic [64:0] full;
        w    = wid(k);
        mk   = (64'd1 << w) - 64'd1;
        full = {1'b0, a & mk} + {1'b0, b & mk} + {64'd0, cin};
        r.s  = full[63:0] & mk;
        r.co = full[w];
        r.ov = (a[w-1] == b[w-1]) && (r.s[w-1] != a[w-1]);
        return r;
    endfunction

    function automatic logic in_vld(input int k);
        return (k == 0) ? if1.in_valid : (k == 1) ? if4.in_valid : if32.in_valid;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input int k, input logic [63:0] a, input logic [63:0] b, input logic cin,
                         input logic v, input logic push_model);
        case (k)
            0: begin if1.a = a[0:0]; if1.b = b[0:0]; if1.carry_in = cin; if1.in_valid = v; end
            1: begin if4.a = a[3:0]; if4.b = b[3:0]; if4.carry_in = cin; if4.in_valid = v; end
            default: begin if32.a = a[31:0]; if32.b = b[31:0]; if32.carry_in = cin; if32.in_valid = v; end
        endcase
        if (v && push_model) q[k].push_back(model(k, a, b, cin));
    endtask

    task automatic get_out(input int k, output exp_t o, output logic vld);
        o = '0;
        case (k)
            0: begin o.s = 64'(if1.sum);  o.co = if1.carry_out;  vld = if1.out_valid;
`ifdef ADDER_OVERFLOW_EN
                o.ov = if1.overflow;
`endif
            end
            1: begin o.s = 64'(if4.sum);  o.co = if4.carry_out;  vld = if4.out_valid;
`ifdef ADDER_OVERFLOW_EN
                o.ov = if4.overflow;
`endif
            end
            default: begin o.s = 64'(if32.sum); o.co = if32.carry_out; vld = if32.out_valid;
`ifdef ADDER_OVERFLOW_EN
                o.ov = if32.overflow;
`endif
            end
        endcase
    endtask

    task automatic idle_all();
        for (int k = 0; k < 3; k++) drive(k, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // One edge: valid results are popped from the scoreboard, idle cycles must hold the last result.
    task automatic tick();
        logic pv[3];
        exp_t o;
        exp_t e;
        logic vld;
        for (int k = 0; k < 3; k++) pv[k] = in_vld(k) && rst_n;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            get_out(k, o, vld);
            chk($sformatf("w%0d_out_valid", wid(k)), 64'(vld), 64'(pv[k]));
            e = last[k];
            if (pv[k]) begin
                if (q[k].size() == 0) begin
                    chk($sformatf("w%0d_sb_empty", wid(k)), 64'd0, 64'd1);
                end else begin
                    e = q[k].pop_front();
                    last[k] = e;
                end
            end
            chk($sformatf("w%0d_sum", wid(k)), o.s, e.s);
            chk($sformatf("w%0d_carry_out", wid(k)), 64'(o.co), 64'(e.co));
`ifdef ADDER_OVERFLOW_EN
            chk($sformatf("w%0d_overflow", wid(k)), 64'(o.ov), 64'(e.ov));
`endif
        end
    endtask

    task automatic chk_zero(input string nm);
        exp_t o;
        logic vld;
        for (int k = 0; k < 3; k++) begin
            get_out(k, o, vld);
            chk($sformatf("%s_w%0d_sum", nm, wid(k)), o.s, 64'd0);
            chk($sformatf("%s_w%0d_cout", nm, wid(k)), 64'(o.co), 64'd0);
            chk($sformatf("%s_w%0d_vld", nm, wid(k)), 64'(vld), 64'd0);
`ifdef ADDER_OVERFLOW_EN
            chk($sformatf("%s_w%0d_ov", nm, wid(k)), 64'(o.ov), 64'd0);
`endif
        end
    endtask

    // Async reset between edges: outputs clear at once, anything in flight is dropped.
    task automatic reset_pulse(input string nm);
        #2 rst_n = 1'b0;
        #1 chk_zero(nm);
        for (int k = 0; k < 3; k++) begin
            q[k].delete();
            last[k] = '0;
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    vec_t tbl[8];

    initial begin
        total = 0;
        bad   = 0;
        for (int k = 0; k < 3; k++) last[k] = '0;
        tbl[0] = '{a: 4'h3, b: 4'h4, cin: 1'b0, s: 4'h7, co: 1'b0, ov: 1'b0};
        tbl[1] = '{a: 4'hF, b: 4'h1, cin: 1'b0, s: 4'h0, co: 1'b1, ov: 1'b0};
        tbl[2] = '{a: 4'h7, b: 4'h1, cin: 1'b0, s: 4'h8, co: 1'b0, ov: 1'b1};
        tbl[3] = '{a: 4'h8, b: 4'h8, cin: 1'b0, s: 4'h0, co: 1'b1, ov: 1'b1};
        tbl[4] = '{a: 4'hF, b: 4'h0, cin: 1'b1, s: 4'h0, co: 1'b1, ov: 1'b0};
        tbl[5] = '{a: 4'h0, b: 4'h0, cin: 1'b0, s: 4'h0, co: 1'b0, ov: 1'b0};
        tbl[6] = '{a: 4'h1, b: 4'h1, cin: 1'b1, s: 4'h3, co: 1'b0, ov: 1'b0};
        tbl[7] = '{a: 4'hF, b: 4'hF, cin: 1'b1, s: 4'hF, co: 1'b1, ov: 1'b0};

        rst_n = 1'b0;
        idle_all();
        #1 chk_zero("por");
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Load sum=A, then reset between edges must clear it immediately.
        drive(1, 64'h5, 64'h5, 1'b0, 1'b1, 1'b1);
        tick();
        idle_all();
        reset_pulse("rst_hold_a");
        tick();

        // Table vectors back to back on the 4-bit instance, expectations from the table.
        for (int i = 0; i < 8; i++) begin
            drive(1, 64'(tbl[i].a), 64'(tbl[i].b), tbl[i].cin, 1'b1, 1'b0);
            q[1].push_back('{s: 64'(tbl[i].s), co: tbl[i].co, ov: tbl[i].ov});
            tick();
        end
        // Idle after (F,F,1): out_valid drops, F / carry 1 held.
        idle_all();
        tick();
        tick();

        // Reset while an operand set is in flight: its result must never appear.
        drive(1, 64'h6, 64'h2, 1'b1, 1'b1, 1'b1);
        drive(2, 64'h1234, 64'h1, 1'b0, 1'b1, 1'b1);
        reset_pulse("rst_mid_op");
        idle_all();
        tick();

        // Random sweep on all widths, with a reset pulse part way through.
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < 3; k++)
                drive(k, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3) != 0, 1'b1);
            if (i == 150) reset_pulse("rst_sweep");
            else tick();
        end
        idle_all();
        tick();

        // Full-range wrap on the wide instance.
        drive(2, 64'hFFFF_FFFF, 64'd0, 1'b1, 1'b1, 1'b1);
        tick();
        idle_all();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
